// File: rtl/ip_codma_read_machine.sv
// CODMA read stage: requests the bus, gathers 1/2/4 64-bit beats into a 256-bit
// staging buffer, pulses need_write_o, then holds the buffer until write_done_i.
module ip_codma_read_machine (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [31:0]  rd_addr_i,
    input  logic [3:0]   rd_size_i,
    input  logic         stop_i,
    output logic         bus_req_o,
    input  logic         bus_grant_i,
    output logic [31:0]  bus_addr_o,
    output logic [3:0]   bus_size_o,
    input  logic [63:0]  bus_rdata_i,
    input  logic         bus_rvalid_i,
    input  logic         bus_error_i,
    output logic         need_write_o,
    input  logic         write_done_i,
    output logic [255:0] rd_data_o,
    output logic [7:0]   word_count_rd_o,
    output logic [1:0]   rd_state_o,
    output logic         rd_state_error_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_ASK     = 2'd1,
        RD_GRANTED = 2'd2,
        RD_WAIT_WR = 2'd3
    } rd_state_e;

    rd_state_e      state_q;
    logic           bus_req_q;
    logic [31:0]    addr_q;
    logic [3:0]     size_q;
    logic           need_write_q;
    logic [255:0]   data_q;
    logic [7:0]     count_q;
    logic           error_q;
    logic           busy_q;

    logic [7:0]     count_d;
    logic [7:0]     slot_base;

    function automatic logic size_legal(input logic [3:0] size);
        return (size == 4'd3) || (size == 4'd8) || (size == 4'd9);
    endfunction

    // Target count is in 32-bit words: two per 64-bit beat.
    function automatic logic [7:0] target_words(input logic [3:0] size);
        case (size)
            4'd3:    return 8'd2;
            4'd8:    return 8'd4;
            default: return 8'd8;
        endcase
    endfunction

    assign count_d   = count_q + 8'd2;
    assign slot_base = {count_q[2:1], 6'd0};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= RD_IDLE;
            bus_req_q    <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            need_write_q <= 1'b0;
            // NOTE: the staging buffer is a plain register bank, not a RAM, so it
            // takes the async reset like every other output.
            data_q       <= '0;
            count_q      <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            need_write_q <= 1'b0;
            if (stop_i) begin
                state_q   <= RD_IDLE;
                bus_req_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    RD_IDLE: begin
                        if (start_i && size_legal(rd_size_i)) begin
                            state_q   <= RD_ASK;
                            bus_req_q <= 1'b1;
                            busy_q    <= 1'b1;
                            addr_q    <= rd_addr_i;
                            size_q    <= rd_size_i;
                            data_q    <= '0;
                            count_q   <= '0;
                            error_q   <= 1'b0;
                        end else if (start_i) begin
                            error_q <= 1'b1;
                        end
                    end
                    RD_ASK: begin
                        if (bus_error_i) begin
                            state_q   <= RD_IDLE;
                            bus_req_q <= 1'b0;
                            busy_q    <= 1'b0;
                            error_q   <= 1'b1;
                        end else if (bus_grant_i) begin
                            state_q <= RD_GRANTED;
                        end
                    end
                    RD_GRANTED: begin
                        if (bus_error_i) begin
                            state_q   <= RD_IDLE;
                            bus_req_q <= 1'b0;
                            busy_q    <= 1'b0;
                            error_q   <= 1'b1;
                        end else if (bus_rvalid_i) begin
                            data_q[slot_base +: 64] <= bus_rdata_i;
                            count_q                 <= count_d;
                            if (count_d == target_words(size_q)) begin
                                state_q      <= RD_WAIT_WR;
                                bus_req_q    <= 1'b0;
                                need_write_q <= 1'b1;
                            end
                        end
                    end
                    RD_WAIT_WR: begin
                        if (write_done_i) begin
                            state_q <= RD_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= RD_IDLE;
                endcase
            end
        end
    end

    assign bus_req_o        = bus_req_q;
    assign bus_addr_o       = addr_q;
    assign bus_size_o       = size_q;
    assign need_write_o     = need_write_q;
    assign rd_data_o        = data_q;
    assign word_count_rd_o  = count_q;
    assign rd_state_o       = state_q;
    assign rd_state_error_o = error_q;
    assign busy_o           = busy_q;

endmodule

// File: doc/ip_codma_read_machine.md
# ip_codma_read_machine

Read stage of the CODMA datapath, directly upstream of the write machine. It accepts a transfer request (source address and size code) and arbitrates for the memory bus. It collects 1, 2 or 4 64-bit read beats into a 256-bit staging buffer, then raises a one-cycle need-write pulse to the write machine. It holds the buffer stable until the write machine reports completion.

## Interface
Parameters:
- none (data beat fixed at 64 bits, buffer fixed at 4 beats)

Ports:
- clk_i  input  1  clock; all logic on rising edge
- reset_i  input  1  asynchronous, active-high reset
- start_i  input  1  transfer request; sampled only in RD_IDLE
- rd_addr_i  input  32  source byte address, captured with start_i
- rd_size_i  input  4  size code: 3 = 1 beat, 8 = 2 beats, 9 = 4 beats
- stop_i  input  1  abort; forces RD_IDLE
- bus_req_o  output  1  bus request
- bus_grant_i  input  1  bus grant
- bus_addr_o  output  32  captured source address
- bus_size_o  output  4  captured size code
- bus_rdata_i  input  64  read data beat
- bus_rvalid_i  input  1  read beat valid
- bus_error_i  input  1  bus error
- need_write_o  output  1  one-cycle pulse: buffer full, write machine may start
- write_done_i  input  1  write machine finished consuming rd_data_o
- rd_data_o  output  256  staging buffer; beat n at bits [64n+63:64n]
- word_count_rd_o  output  8  32-bit words received (increments by 2 per beat)
- rd_state_o  output  2  current state encoding
- rd_state_error_o  output  1  sticky error flag
- busy_o  output  1  high whenever state is not RD_IDLE

## Operation
- States (encoding): RD_IDLE=0, RD_ASK=1, RD_GRANTED=2, RD_WAIT_WR=3.
- RD_IDLE to RD_ASK: on start_i with a legal size code (3, 8 or 9).
  - On that edge: capture rd_addr_i/rd_size_i, clear word_count_rd_o, clear rd_data_o, clear rd_state_error_o.
- Illegal size with start_i: stay in RD_IDLE and set rd_state_error_o. No bus request is issued.
- RD_ASK to RD_GRANTED: on bus_grant_i.
- RD_GRANTED: each cycle with bus_rvalid_i:
  - write bus_rdata_i into buffer slot word_count_rd_o/2;
  - add 2 to word_count_rd_o.
- RD_GRANTED to RD_WAIT_WR: on the beat that brings the count to the target. Targets: size 3 = 2, size 8 = 4, size 9 = 8.
- bus_rvalid_i outside RD_GRANTED is ignored; buffer and count are unchanged.
- RD_WAIT_WR to RD_IDLE: on write_done_i. Buffer and count hold until the next accepted start_i.
- bus_req_o = 1 in RD_ASK and RD_GRANTED, else 0.
- bus_addr_o and bus_size_o hold their captured values.
- bus_error_i in RD_ASK or RD_GRANTED: go to RD_IDLE next cycle, set rd_state_error_o, no need_write_o pulse. Ignored in other states.
- stop_i: go to RD_IDLE from any state, no need_write_o.
  - Priority: reset > stop_i > bus_error_i > normal transitions.
  - stop_i together with start_i in RD_IDLE: start is not accepted.
- rd_state_error_o stays set until reset or the next accepted start_i.

## Timing
- Reset values: all outputs 0; state RD_IDLE; rd_data_o all zero.
- start_i at edge N: bus_req_o = 1 after edge N.
- Grant at edge M: state is RD_GRANTED after M. The first beat is accepted from edge M+1 onward.
- Final beat at edge K:
  - state is RD_WAIT_WR after K;
  - need_write_o = 1 for exactly the cycle after K;
  - rd_data_o and word_count_rd_o are final after K.
- Minimum 1-beat transfer: start to need_write_o is 3 cycles (with grant and rvalid each returned at the earliest cycle).
- write_done_i at edge W: RD_IDLE and busy_o = 0 after W. A new start_i is accepted at W+1 at the earliest.
- write_done_i and need_write_o in the same cycle: write_done_i is ignored unless the state is RD_WAIT_WR.
- Reset asserted mid-transfer: immediate return to reset values, independent of the clock.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Size 3, addr 0x1000, grant after 2 cycles, rdata 0xA5A5_0000_1111_2222:
  - need_write_o pulses once;
  - rd_data_o[63:0] = 0xA5A5000011112222, upper bits 0;
  - word_count_rd_o = 2;
  - write_done_i then returns busy_o to 0.
- Size 9, four beats 0x1..0x4 with one idle rvalid gap:
  - rd_data_o = {0x4, 0x3, 0x2, 0x1} in slots 3..0;
  - word_count_rd_o = 8;
  - need_write_o exactly one cycle, only after the 4th beat.
- Size 8, bus_error_i after the first beat:
  - RD_IDLE next cycle, rd_state_error_o = 1, need_write_o never asserted;
  - the next legal start_i clears rd_state_error_o.
- stop_i during RD_ASK, and stop_i with start_i in RD_IDLE:
  - state RD_IDLE, bus_req_o = 0 the following cycle, no need_write_o.
- rd_size_i = 5 with start_i: stays RD_IDLE, bus_req_o stays 0, rd_state_error_o = 1.
- Async reset_i asserted mid-RD_GRANTED (after 1 of 4 beats): all outputs 0 immediately, with no clock edge required.
